cacheline_adapter: RTL
======================

# cacheline_adapter

Memory-side responder for the data cache controller. It accepts one 256-bit cacheline read or write request from the cache (`pmem_read`/`pmem_write`/`pmem_resp` handshake) and converts it into a 4-beat, 64-bit burst transaction on the physical-memory port. It sits between the cache datapath/controller and main memory, and it returns exactly one `resp_o` pulse per completed line.

## Interface
Parameters:
- `LINE_WIDTH`, 256, cacheline width in bits.
- `BURST_WIDTH`, 64, memory beat width in bits. `BEATS = LINE_WIDTH/BURST_WIDTH` = 4 and must be a power of two.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `read_i`  in  1  cache line-read request; held until `resp_o`.
- `write_i`  in  1  cache line-write request; held until `resp_o`.
- `address_i`  in  32  line address from the cache.
- `line_i`  in  LINE_WIDTH  line data to write.
- `line_o`  out  LINE_WIDTH  assembled read line; valid while `resp_o`=1.
- `resp_o`  out  1  one-cycle completion pulse to the cache.
- `read_o`  out  1  burst read request to memory.
- `write_o`  out  1  burst write request to memory.
- `address_o`  out  32  line-aligned burst address.
- `burst_o`  out  BURST_WIDTH  write beat data.
- `burst_i`  in  BURST_WIDTH  read beat data; valid when `resp_i`=1.
- `resp_i`  in  1  per-beat acknowledge from memory.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Registers: `line_buf` (LINE_WIDTH), `addr_q` (32), 2-bit `beat` counter.
- IDLE:
  - If `write_i`=1, latch `address_i` with bits [4:0] forced to 0 into `addr_q`, latch `line_i` into `line_buf`, clear `beat`, and go to WRITE.
  - Otherwise, if `read_i`=1, latch the aligned address, clear `beat`, and go to READ.
  - Write has priority when both requests are high.
  - `resp_i` in IDLE is ignored.
- READ: `read_o`=1. On each `resp_i`=1, store `burst_i` into `line_buf[beat*64 +: 64]` and increment `beat`. When `resp_i` arrives with `beat`=3, go to DONE.
- WRITE: `write_o`=1 and `burst_o = line_buf[beat*64 +: 64]`. Beat 0 is bits [63:0]. On each `resp_i`=1, increment `beat`. When `resp_i` arrives with `beat`=3, go to DONE.
- `resp_i`=0 cycles stall the burst; the beat does not advance, and `read_o`/`write_o` stay high.
- DONE: `resp_o`=1 for exactly one cycle, then go to IDLE unconditionally. The cache's still-asserted request in the DONE cycle is not re-accepted.
- `line_o = line_buf` at all times. It holds its value until the next accept.
- `address_o = addr_q` at all times, stable for the whole burst.
- Outputs are Moore decodes of state: `read_o` = (state==READ), `write_o` = (state==WRITE), `resp_o` = (state==DONE).
- Request changes on `read_i`/`write_i`/`address_i`/`line_i` mid-burst are ignored.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state goes to IDLE and `beat` to 0;
  - `line_buf` and `addr_q` go to 0;
  - all outputs are therefore 0.
- Reset mid-burst aborts immediately with no `resp_o`. Memory must tolerate a dropped request.
- Accept is the edge at which IDLE sees a request (cycle 0). `read_o`/`write_o` rise in cycle 1.
- With `resp_i` high in cycles 1–4, DONE is cycle 5, so `resp_o` is high in cycle 5. Minimum request-to-`resp_o` latency is 5 cycles; each stall cycle adds one.
- A new request is accepted in cycle 6 at the earliest, which supports the cache's write-back-then-read sequence: the cache asserts `read_i` in the same cycle as write completion.
- `line_o` is valid in the `resp_o` cycle: all 4 beats are already registered.

## Test plan
- Read, no stalls: `read_i`, `address_i`=0x1234_5678; memory returns beats 0x0..0x3 with `resp_i` in cycles 1–4 -> `address_o`=0x1234_5660, `read_o` high cycles 1–4, `resp_o` only in cycle 5, `line_o`={0x3,0x2,0x1,0x0}.
- Write with stalls: `line_i`={D3,D2,D1,D0}, `resp_i` pattern 1,0,0,1,1,0,1 -> `burst_o` shows D0,D1,D1,D1,D2,D3,D3 over those cycles, `write_o` held, `resp_o` one cycle after the 4th ack.
- Write-back then read: `write_i` then `read_i` asserted in the `resp_o` cycle with a new address -> no re-accept in DONE, read accepted in the following cycle, new `address_o`, two distinct `resp_o` pulses.
- Both `read_i` and `write_i` high -> WRITE performed (`write_o`=1, `read_o`=0).
- `rst_n`=0 after 2 read beats -> next cycle all outputs 0 and no `resp_o`; a fresh read then completes normally with 4 new beats.
- Spurious `resp_i` in IDLE, and `address_i` changed mid-burst -> no state change, and `address_o` stays at the latched value.

Source files
------------

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: converts one cacheline read/write request into a
// fixed-length burst of narrower memory beats, with a one-cycle completion pulse.
module cacheline_adapter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [31:0]            address_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [31:0]            address_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [31:0]   ALIGN_MASK = ~32'(LINE_WIDTH / 8 - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic [31:0]             addr_q, addr_d;
    logic [BW-1:0]           beat_q, beat_d;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            line_q  <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state: accept in IDLE (write wins), step beats on each memory ack.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    state_d = WRITE;
                    addr_d  = address_i & ALIGN_MASK;
                    line_d  = line_i;
                    beat_d  = '0;
                end else if (read_i) begin
                    state_d = READ;
                    addr_d  = address_i & ALIGN_MASK;
                    beat_d  = '0;
                end
            end
            READ: begin
                if (resp_i) begin
                    line_d[beat_q*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs; the line and address come straight from the registers.
    always_comb begin
        read_o    = (state_q == READ);
        write_o   = (state_q == WRITE);
        resp_o    = (state_q == DONE);
        line_o    = line_q;
        address_o = addr_q;
        burst_o   = line_q[beat_q*BURST_WIDTH +: BURST_WIDTH];
    end

endmodule
